mul_shift5_arb: RTL and testbench

- Shares one 30x5 shift-add multiplier among NUM_REQ requesters in the attention datapath, such as scaling and exponent-approximation lanes.
- Arbitration is round-robin with a valid/ready request handshake.
- Operands and result are registered around the combinational multiplier core.
- Each result is returned with a one-hot tag naming the requester that issued it.
- Sustains one multiply per cycle.

---
 rtl/mul_shift5_arb.sv | 104 ++++++++++
 tb/tb_mul_shift5_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_shift5_arb.sv
// rtl/mul_shift5_arb.sv - round-robin shared shift-add multiplier (A_W x B_W) with one-hot result tags
module mul_shift5_arb #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 30,
    parameter int B_W     = 5
) (
    input  logic                   I_CLK,
    input  logic                   I_RST,
    input  logic [NUM_REQ-1:0]     I_REQ_VLD,
    input  logic [NUM_REQ*A_W-1:0] I_REQ_A,
    input  logic [NUM_REQ*B_W-1:0] I_REQ_B,
    output logic [NUM_REQ-1:0]     O_REQ_RDY,
    output logic [NUM_REQ-1:0]     O_RES_VLD,
    output logic [A_W-1:0]         O_RES,
    output logic                   O_BUSY
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    logic [PW-1:0]      ptr_next;
    logic               hs;
    logic [NUM_REQ-1:0] grant;

    logic               s1_vld;
    logic [A_W-1:0]     s1_a;
    logic [B_W-1:0]     s1_b;
    logic [NUM_REQ-1:0] s1_id;
    logic [A_W-1:0]     prod;

    // Search PTR, PTR+1, ... wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        logic [PW:0] idx;
        grant = '0;
        gidx  = '0;
        hs    = 1'b0;
        idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = {1'b0, ptr} + (PW+1)'(off);
            if (idx >= (PW+1)'(NUM_REQ)) begin
                idx = idx - (PW+1)'(NUM_REQ);
            end
            if (!hs && I_REQ_VLD[idx[PW-1:0]]) begin
                hs   = 1'b1;
                gidx = idx[PW-1:0];
            end
        end
        if (I_RST) begin
            hs = 1'b0;
        end
        if (hs) begin
            grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        logic [PW:0] inc;
        inc = {1'b0, gidx} + (PW+1)'(1);
        if (inc == (PW+1)'(NUM_REQ)) begin
            ptr_next = '0;
        end else begin
            ptr_next = inc[PW-1:0];
        end
    end

    // Shift-add product; carries past bit A_W-1 are dropped.
    always_comb begin
        prod = '0;
        for (int k = 0; k < B_W; k++) begin
            if (s1_b[k]) begin
                prod = prod + (s1_a << k);
            end
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            ptr       <= '0;
            s1_vld    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= '0;
            O_RES_VLD <= '0;
            O_RES     <= '0;
        end else begin
            if (hs) begin
                ptr    <= ptr_next;
                s1_vld <= 1'b1;
                s1_a   <= I_REQ_A[gidx*A_W +: A_W];
                s1_b   <= I_REQ_B[gidx*B_W +: B_W];
                s1_id  <= grant;
            end else begin
                s1_vld <= 1'b0;
            end
            O_RES     <= prod;
            O_RES_VLD <= s1_vld ? s1_id : '0;
        end
    end

    assign O_REQ_RDY = grant;
    assign O_BUSY    = s1_vld | (|O_RES_VLD);

endmodule

// File: tb/tb_mul_shift5_arb.sv
// tb/tb_mul_shift5_arb.sv - self-checking bench for mul_shift5_arb
module tb_mul_shift5_arb;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int BW = 5;
    localparam logic [63:0] MASK = (64'd1 << AW) - 64'd1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    vld;
    logic [AW-1:0]   a [N];
    logic [BW-1:0]   b [N];
    logic [N*AW-1:0] a_bus;
    logic [N*BW-1:0] b_bus;
    logic [N-1:0]    rdy;
    logic [N-1:0]    res_vld;
    logic [AW-1:0]   res;
    logic            busy;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign a_bus[gi*AW +: AW] = a[gi];
        assign b_bus[gi*BW +: BW] = b[gi];
    end

    mul_shift5_arb #(.NUM_REQ(N), .A_W(AW), .B_W(BW)) dut (
        .I_CLK     (clk),
        .I_RST     (rst),
        .I_REQ_VLD (vld),
        .I_REQ_A   (a_bus),
        .I_REQ_B   (b_bus),
        .O_REQ_RDY (rdy),
        .O_RES_VLD (res_vld),
        .O_RES     (res),
        .O_BUSY    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: grant chosen by scanning from the pointer, result = A*B mod 2^AW
    int           m_ptr;
    logic         m_s1_vld;
    logic [N-1:0] m_s1_tag, m_out_tag, m_grant;
    logic [63:0]  m_s1_val, m_out_val;

    always @(negedge clk) begin
        int           g;
        logic [N-1:0] eg;
        if (rst) begin
            check("rst_rdy", 64'(rdy), 64'd0);
            check("rst_res_vld", 64'(res_vld), 64'd0);
            check("rst_res", 64'(res), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            m_ptr = 0; m_s1_vld = 1'b0; m_s1_tag = '0; m_s1_val = '0;
            m_out_tag = '0; m_out_val = '0; m_grant = '0;
        end else begin
            g = -1;
            for (int j = 0; j < N; j++) begin
                if (g < 0 && vld[(m_ptr + j) % N]) g = (m_ptr + j) % N;
            end
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            check("model_rdy", 64'(rdy), 64'(eg));
            check("model_res_vld", 64'(res_vld), 64'(m_out_tag));
            check("model_res", 64'(res), m_out_val);
            check("model_busy", 64'(busy), 64'(m_s1_vld || (m_out_tag != '0)));
            m_out_tag = m_s1_vld ? m_s1_tag : '0;
            m_out_val = m_s1_val;
            if (g >= 0) begin
                m_s1_vld = 1'b1;
                m_s1_tag = eg;
                m_s1_val = (64'(a[g]) * 64'(b[g])) & MASK;
                m_ptr    = (g + 1) % N;
            end else begin
                m_s1_vld = 1'b0;
            end
            m_grant = eg;
        end
    end

    typedef struct {
        int             id;
        logic [AW-1:0]  av;
        logic [BW-1:0]  bv;
        logic [AW-1:0]  exp;
    } vec_t;

    vec_t vt [4];

    initial begin
        vt[0] = '{0, 30'd3, 5'd5, 30'd15};
        vt[1] = '{1, 30'h3FFFFFFF, 5'd31, 30'h3FFFFFE1};
        vt[2] = '{1, 30'h12345, 5'd0, 30'd0};
        vt[3] = '{1, 30'd0, 5'd31, 30'd0};

        vld = '0;
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // single-request vectors: grant same cycle, tagged result two cycles later
        for (int v = 0; v < 4; v++) begin
            vld[vt[v].id] = 1'b1;
            a[vt[v].id]   = vt[v].av;
            b[vt[v].id]   = vt[v].bv;
            #1 check("vec_rdy", 64'(rdy), 64'(N'(1) << vt[v].id));
            tick();
            vld = '0;
            tick();
            check("vec_res_vld", 64'(res_vld), 64'(N'(1) << vt[v].id));
            check("vec_res", 64'(res), 64'(vt[v].exp));
        end

        // park the pointer at 0 via a single req3 grant
        vld = 4'b1000;
        tick();
        vld = '0;
        repeat (2) tick();

        // all four requesters valid for 8 cycles
        for (int i = 0; i < N; i++) begin
            a[i] = AW'(i + 1);
            b[i] = 5'd2;
        end
        for (int c = 0; c < 10; c++) begin
            vld = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) check("rr_rdy", 64'(rdy), 64'(N'(1) << (c % 4)));
            if (c >= 2) begin
                check("rr_res_vld", 64'(res_vld), 64'(N'(1) << ((c - 2) % 4)));
                check("rr_res", 64'(res), 64'(2 * (((c - 2) % 4) + 1)));
            end
            if (c >= 1) check("rr_busy", 64'(busy), 64'd1);
            tick();
        end

        // sole requester granted back-to-back, then pointer sits at 3
        a[2] = 30'd7;
        b[2] = 5'd3;
        vld  = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1 check("solo_rdy", 64'(rdy), 64'h4);
            tick();
        end
        vld = 4'b1001;
        #1 check("ptr3_rdy", 64'(rdy), 64'h8);
        tick();
        vld = 4'b0001;
        #1 check("ptr0_rdy", 64'(rdy), 64'h1);
        tick();
        vld = '0;
        repeat (3) tick();

        // reset right after a handshake drops the in-flight operation
        a[0] = 30'd5;
        b[0] = 5'd5;
        vld  = 4'b0001;
        tick();
        vld = 4'b0011;
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", 64'(rdy), 64'd0);
        check("mid_rst_res_vld", 64'(res_vld), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_res", 64'(res), 64'd0);
        tick();
        rst = 1'b0;
        #1 check("post_rst_rdy", 64'(rdy), 64'h1);
        check("post_rst_res_vld", 64'(res_vld), 64'd0);
        tick();
        vld = 4'b0010;
        #1 check("post_rst_rdy2", 64'(rdy), 64'h2);
        tick();
        vld = '0;
        repeat (3) tick();

        // random traffic; a valid requester keeps its operands until granted
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!(vld[i] && !m_grant[i])) begin
                    int sa, sb;
                    vld[i] = ($urandom_range(0, 2) != 0);
                    sa = $urandom_range(0, 9);
                    sb = $urandom_range(0, 9);
                    a[i] = (sa == 0) ? '0 : (sa == 1) ? '1 : AW'($urandom);
                    b[i] = (sb == 0) ? '0 : (sb == 1) ? '1 : BW'($urandom);
                end
            end
            tick();
        end
        vld = '0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
